// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one external memory port between a cpu requester (port 0) and a
//           loader/DMA requester (port 1), one transaction in flight, round-robin on ties.
// Latency : mem_req rises 1 cycle after a request is sampled; doneN pulses 1 cycle after
//           mem_done (or after TIMEOUT cycles of BUSY with errN); min 3 cycles per transaction.
// Backpressure: requesters hold reqN until doneN; the losing requester simply waits.
//
// Ports:
//   clk, reset            clock (posedge) and synchronous active-low reset
//   reqN/rwN/addrN/wdataN requester N command, held stable while reqN is high
//   rdataN/doneN/errN     requester N response, doneN/errN are one-cycle pulses
//   grant                 one-hot current owner, 2'b00 when idle
//   mem_req/rw/addr/wdata latched command towards memory
//   mem_rdata/mem_done    memory response, honoured only while BUSY
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,   // 0 disables the timeout; must be < 2**TOW
    parameter int TOW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic [DW-1:0] rdata0,
    output logic          done0,
    output logic          err0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata1,
    output logic          done1,
    output logic          err1,
    output logic [1:0]    grant,
    output logic          mem_req,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam bit            TO_EN   = (TIMEOUT != 0);
    // Counter value at which the last permitted BUSY cycle is being evaluated.
    localparam logic [TOW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TOW'(TIMEOUT - 1);

    state_t         state;
    logic           owner;       // port index of the current transaction
    logic           last_owner;  // port served last; resets to 1 so port 0 wins the first tie
    logic [TOW-1:0] count;
    logic           pick;

    // Single requester wins outright; on a tie the port not served last time wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_owner;
        end else begin
            pick = req1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            count      <= '0;
            grant      <= 2'b00;
            mem_req    <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= pick;
                        last_owner <= pick;
                        grant      <= pick ? 2'b10 : 2'b01;
                        mem_req    <= 1'b1;
                        mem_rw     <= pick ? rw1 : rw0;
                        mem_addr   <= pick ? addr1 : addr0;
                        mem_wdata  <= pick ? wdata1 : wdata0;
                        count      <= '0;
                        state      <= BUSY;
                    end
                end

                BUSY: begin
                    count <= count + 1'b1;
                    // mem_done takes priority over a timeout landing on the same edge.
                    if (mem_done) begin
                        if (owner) begin
                            rdata1 <= mem_rdata;
                            done1  <= 1'b1;
                        end else begin
                            rdata0 <= mem_rdata;
                            done0  <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        grant   <= 2'b00;
                        state   <= RELEASE;
                    end else if (TO_EN && (count == TO_LAST)) begin
                        if (owner) begin
                            rdata1 <= '0;
                            done1  <= 1'b1;
                            err1   <= 1'b1;
                        end else begin
                            rdata0 <= '0;
                            done0  <= 1'b1;
                            err0   <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        grant   <= 2'b00;
                        state   <= RELEASE;
                    end
                end

                RELEASE: begin
                    // Requests are ignored here so the finished requester can drop reqN.
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of single transactions (reads, writes, timeout,
// done/timeout race) plus hand sequences for contention and reset mid-transaction.
module tb_mem_bus_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int TOW     = 8;
    localparam int NEVER   = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, rw0, req1, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic          done0, done1, err0, err1;
    logic [1:0]    grant;
    logic          mem_req, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .done0(done0), .err0(err0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .done1(done1), .err1(err1),
        .grant(grant), .mem_req(mem_req), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    typedef struct {
        bit          port;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;   // what memory returns
        int          lat;      // cycles after mem_req first seen before mem_done; NEVER = none
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_nreq; // cycles mem_req is seen high
    } vec_t;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          nreq;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rd[2];
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit done_of(input bit p);
        return p ? done1 : done0;
    endfunction

    function automatic bit err_of(input bit p);
        return p ? err1 : err0;
    endfunction

    function automatic logic [31:0] rdata_of(input bit p);
        return p ? rdata1 : rdata0;
    endfunction

    task automatic set_req(input bit p, input bit v, input bit rw,
                           input logic [31:0] a, input logic [31:0] w);
        if (p) begin
            req1 = v; rw1 = rw; addr1 = a; wdata1 = w;
        end else begin
            req0 = v; rw0 = rw; addr0 = a; wdata0 = w;
        end
    endtask

    function automatic vec_t mk(input bit p, input bit rw, input logic [31:0] a,
                                input logic [31:0] w, input logic [31:0] mr, input int lat,
                                input bit e, input logic [31:0] erd, input int en);
        vec_t v;
        v.port = p; v.rw = rw; v.addr = a; v.wdata = w; v.mrdata = mr; v.lat = lat;
        v.exp_err = e; v.exp_rdata = erd; v.exp_nreq = en;
        return v;
    endfunction

    // Called just after a negedge; returns just after a negedge.
    task automatic do_txn(input vec_t v);
        exp_t        e;
        logic [31:0] other_rd;
        int          nreq  = 0;
        bit          fin   = 0;
        bit          stray = 0;
        set_req(v.port, 1'b1, v.rw, v.addr, v.wdata);
        sb.push_back('{v.port, v.exp_err, v.exp_rdata, v.exp_nreq});
        other_rd = exp_rd[!v.port];
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            mem_done = 1'b0;
            if (done_of(!v.port) || err_of(!v.port)) stray = 1'b1;
            if (done_of(v.port)) begin
                fin = 1'b1;
                e = sb.pop_front();
                check("err", err_of(e.port), e.err);
                check("rdata", rdata_of(e.port), e.rdata);
                check("mem_req_low", mem_req, 0);
                check("grant_clr", grant, 0);
                check("mem_req_cycles", nreq, e.nreq);
                check("other_rdata_hold", rdata_of(!e.port), other_rd);
                exp_rd[e.port] = e.rdata;
                set_req(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (mem_req) begin
                if (nreq == 0) begin
                    check("mem_addr", mem_addr, v.addr);
                    check("mem_rw", mem_rw, v.rw);
                    check("mem_wdata", mem_wdata, v.wdata);
                    check("grant", grant, v.port ? 2'b10 : 2'b01);
                    // Disturb the held command; the latched copy must not follow.
                    set_req(v.port, 1'b1, ~v.rw, ~v.addr, ~v.wdata);
                end
                if (nreq == 1) check("mem_addr_hold", mem_addr, v.addr);
                if (nreq == v.lat) begin
                    mem_done  = 1'b1;
                    mem_rdata = v.mrdata;
                end
                nreq++;
            end
        end
        if (!fin) check("done_seen", 0, 1);
        check("other_port_quiet", stray, 0);
        @(negedge clk);
        check("done_pulse", done_of(v.port), 0);
        check("err_pulse", err_of(v.port), 0);
    endtask

    vec_t       vecs[9];
    logic [1:0] grants[4];
    logic [1:0] exp_grants[4];
    int         ng, d0, d1;
    bit         prev_req;

    initial begin
        reset = 1'b0; mem_done = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        req0 = 1'b1; rw0 = 1'b1; addr0 = 32'h1; wdata0 = 32'h2;
        req1 = 1'b0; rw1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_rw", mem_rw, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_err", {err1, err0}, 0);
        req0 = 1'b0; rw0 = 1'b0; mem_done = 1'b0; reset = 1'b1;
        @(negedge clk);

        vecs[0] = mk(0, 0, 32'h40,  32'h0,        32'hDEADBEEF, 3,     0, 32'hDEADBEEF, 4);
        vecs[1] = mk(1, 1, 32'h100, 32'h12345678, 32'hA5A5A5A5, 2,     0, 32'hA5A5A5A5, 3);
        vecs[2] = mk(0, 0, 32'h44,  32'h0,        32'h11111111, 0,     0, 32'h11111111, 1);
        vecs[3] = mk(0, 0, 32'h48,  32'h0,        32'h99999999, NEVER, 1, 32'h0,        16);
        vecs[4] = mk(0, 0, 32'h4C,  32'h0,        32'h22222222, 1,     0, 32'h22222222, 2);
        vecs[5] = mk(1, 0, 32'h200, 32'h0,        32'hCAFEF00D, 15,    0, 32'hCAFEF00D, 16);
        vecs[6] = mk(1, 0, 32'h204, 32'h0,        32'h33333333, 14,    0, 32'h33333333, 15);
        vecs[7] = mk(0, 1, 32'h50,  32'hFEEDFACE, 32'h44444444, 5,     0, 32'h44444444, 6);
        vecs[8] = mk(0, 0, 32'h80,  32'h0,        32'h5A5A5A5A, 2,     0, 32'h5A5A5A5A, 3);

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Contention straight out of reset: grants must alternate starting with port 0.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        exp_grants[0] = 2'b01; exp_grants[1] = 2'b10;
        exp_grants[2] = 2'b01; exp_grants[3] = 2'b10;
        for (int i = 0; i < 4; i++) grants[i] = 2'b00;
        ng = 0; d0 = 0; d1 = 0; prev_req = 1'b0;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h300;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 32'h400;
        for (int c = 0; c < 80 && (d0 + d1) < 4; c++) begin
            @(negedge clk);
            mem_done = 1'b0;
            if (done0) d0++;
            if (done1) d1++;
            if (mem_req && !prev_req) begin
                if (ng < 4) grants[ng] = grant;
                ng++;
                mem_done  = 1'b1;
                mem_rdata = 32'h1000 + ng;
            end
            prev_req = mem_req;
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grants[i], exp_grants[i]);
        check("rr_done0_count", d0, 2);
        check("rr_done1_count", d1, 2);
        @(negedge clk);

        // Reset while BUSY: transaction abandoned silently, late mem_done ignored.
        req0 = 1'b1; rw0 = 1'b0; addr0 = 32'h80;
        for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
        check("midrst_busy", mem_req, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_grant", grant, 0);
        check("midrst_done_err", {done0, err0, done1, err1}, 0);
        reset = 1'b1; req0 = 1'b0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        mem_done = 1'b0;
        @(negedge clk);
        check("stray_done_ignored", {done0, done1, mem_req}, 0);
        check("stray_rdata0", rdata0, 0);
        do_txn(vecs[8]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
